// File: rtl/seq_ones_pkg.sv
// seq_ones_pkg: shared types for the consecutive-ones pattern transmitter.
// State encoding and the default run length that makes one detection.
package seq_ones_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int RUN_LEN_DEF = 3;

endpackage

// File: rtl/seq_ones_ref_counter.sv
// seq_ones_ref_counter: overlapping run-of-ones detection counter.
// Tracks the current run of ones and accumulates saturating detections.
module seq_ones_ref_counter
  import seq_ones_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  localparam int RW = $clog2(RUN_LEN + 1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_inc;
  logic          hit;

  // next run length if this bit is a one, and whether it completes a run
  always_comb begin
    run_inc = (run == RW'(RUN_LEN)) ? run : run + 1'b1;
    hit     = bit_in && (run_inc == RW'(RUN_LEN));
  end

  // run tracker and saturating detection accumulator
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      run   <= '0;
      count <= '0;
    end else if (bit_valid) begin
      run <= bit_in ? run_inc : '0;
      if (hit && (count != '1))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_ones_tx.sv
// seq_ones_tx: MSB-first serial pattern transmitter with expected-count output.
// Optional one-cycle zero tail after the pattern: define SEQ_TX_TAIL_EN.
module seq_ones_tx
  import seq_ones_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LEN_W   = $clog2(WIDTH + 1),
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] exp_count
);

`ifdef SEQ_TX_TAIL_EN
  localparam state_t ST_POST = ST_TAIL;
`else
  localparam state_t ST_POST = ST_DONE;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] remain;
  logic [LEN_W-1:0] len_sat;
  logic             accept;

  // clamp the requested length to the pattern width
  always_comb begin
    len_sat = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
    accept  = load_valid && load_ready;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next state and Moore outputs
  always_comb begin
    state_nxt      = state;
    load_ready     = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    data_out_valid = 1'b0;
    data_out       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid)
          state_nxt = (len_sat != '0) ? ST_SEND : ST_POST;
      end
      ST_SEND: begin
        busy           = 1'b1;
        data_out_valid = 1'b1;
        data_out       = shreg[WIDTH-1];
        if (remain == '0)
          state_nxt = ST_POST;
      end
      ST_TAIL: begin
        busy           = 1'b1;
        data_out_valid = 1'b1;
        state_nxt      = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // left-justified shift register and remaining-bit index
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      remain <= '0;
    end else if (accept) begin
      shreg  <= load_data << (LEN_W'(WIDTH) - len_sat);
      remain <= len_sat - 1'b1;
    end else if (state == ST_SEND) begin
      shreg  <= shreg << 1;
      remain <= remain - 1'b1;
    end
  end

  seq_ones_ref_counter #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (LEN_W)
  ) u_ref (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_valid (data_out_valid),
    .bit_in    (data_out),
    .count     (exp_count)
  );

endmodule

// File: tb/tb_seq_ones_tx.sv
// tb_seq_ones_tx: scoreboard bench for the serial pattern transmitter.
// Expected bits are queued at accept and popped as the DUT shifts them out.
module tb_seq_ones_tx;

  localparam int W  = 16;
  localparam int LW = 5;
  localparam int RL = 3;
`ifdef SEQ_TX_TAIL_EN
  localparam int TL = 1;
`else
  localparam int TL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_data;
  logic [LW-1:0] load_len;
  logic          data_out;
  logic          data_out_valid;
  logic          busy;
  logic          done;
  logic [LW-1:0] exp_count;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic exp_b;

  always #5 clk = ~clk;

  seq_ones_tx #(.WIDTH(W), .LEN_W(LW), .RUN_LEN(RL)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_data      (load_data),
    .load_len       (load_len),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .done           (done),
    .exp_count      (exp_count)
  );

  // scoreboard: every valid serial bit must match the queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bit_unexpected got=%0b required=none", data_out);
        end else begin
          exp_b = exp_q.pop_front();
          if (data_out !== exp_b) begin
            bad++;
            $display("FAIL serial_bit got=%0b required=%0b", data_out, exp_b);
          end
        end
      end else if (data_out !== 1'b0) begin
        bad++;
        $display("FAIL idle_zero got=%0b required=0", data_out);
      end
    end
  end

  function automatic int model_cnt(input logic [W-1:0] d, input int l);
    int ls;
    int run;
    int c;
    ls  = (l > W) ? W : l;
    run = 0;
    c   = 0;
    for (int i = ls - 1; i >= 0; i--) begin
      run = d[i] ? run + 1 : 0;
      if (run >= RL) c++;
    end
    return c;
  endfunction

  task automatic accept(input logic [W-1:0] d, input logic [LW-1:0] l,
                        output int w);
    int ls;
    load_data  = d;
    load_len   = l;
    load_valid = 1'b1;
    w = 0;
    while (!load_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk);
    ls = (int'(l) > W) ? W : int'(l);
    for (int i = ls - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (TL == 1) exp_q.push_back(1'b0);
    #1;
  endtask

  task automatic run_xfer(input logic [W-1:0] d, input logic [LW-1:0] l,
                          input bit hold, output int k, output int w,
                          output logic [LW-1:0] cnt, output bit rdy);
    accept(d, l, w);
    if (!hold) load_valid = 1'b0;
    k   = 0;
    rdy = 1'b0;
    while (done !== 1'b1 && k < 60) begin
      if (load_ready) rdy = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    cnt = exp_count;
  endtask

  task automatic test_reset;
    if ({load_ready, data_out, data_out_valid, busy, done} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=10000",
               {load_ready, data_out, data_out_valid, busy, done});
    end
    total++;
    if (exp_count !== '0) begin
      bad++;
      $display("FAIL reset_count got=%0d required=0", exp_count);
    end
    total++;
  endtask

  task automatic test_basic;
    logic [W-1:0]  td[4] = '{16'b111, 16'b111111, 16'b110, 16'hAA};
    logic [LW-1:0] tl[4] = '{5'd3, 5'd6, 5'd3, 5'd8};
    int            tc[4] = '{1, 4, 0, 0};
    int            k;
    int            w;
    logic [LW-1:0] cnt;
    bit            rdy;
    for (int n = 0; n < 4; n++) begin
      run_xfer(td[n], tl[n], 1'b0, k, w, cnt, rdy);
      total++;
      if (k != int'(tl[n]) + TL) begin
        bad++;
        $display("FAIL done_latency case=%0d got=%0d required=%0d",
                 n + 1, k, int'(tl[n]) + TL);
      end
      total++;
      if (int'(cnt) != tc[n]) begin
        bad++;
        $display("FAIL exp_count case=%0d got=%0d required=%0d",
                 n + 1, cnt, tc[n]);
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL bits_left case=%0d got=%0d required=0",
                 n + 1, exp_q.size());
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL done_pulse case=%0d got=%b%b required=01",
                 n + 1, done, load_ready);
      end
      total++;
      if (int'(exp_count) != tc[n]) begin
        bad++;
        $display("FAIL count_hold case=%0d got=%0d required=%0d",
                 n + 1, exp_count, tc[n]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0]  d = 16'b1101110110;
    int            k;
    int            w;
    logic [LW-1:0] cnt;
    bit            rdy;
    run_xfer(d, 5'd10, 1'b1, k, w, cnt, rdy);
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_send got=1 required=0");
    end
    total++;
    if (int'(cnt) != model_cnt(d, 10) || cnt !== 5'd1) begin
      bad++;
      $display("FAIL b2b_count1 got=%0d required=1", cnt);
    end
    run_xfer(d, 5'd10, 1'b0, k, w, cnt, rdy);
    total++;
    if (w != 1) begin
      bad++;
      $display("FAIL b2b_wait got=%0d required=1", w);
    end
    total++;
    if (k != 10 + TL || cnt !== 5'd1) begin
      bad++;
      $display("FAIL b2b_second got=%0d/%0d required=%0d/1", k, cnt, 10 + TL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int w;
    accept(16'b111111, 5'd6, w);
    load_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b required=1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    test_reset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (done !== 1'b0 || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort_nodone cyc=%0d got=%b%b required=01",
                 i, done, load_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len_edges;
    int            k;
    int            w;
    logic [LW-1:0] cnt;
    bit            rdy;
    run_xfer(16'hFFFF, 5'd0, 1'b0, k, w, cnt, rdy);
    total++;
    if (k != TL || cnt !== 5'd0) begin
      bad++;
      $display("FAIL len0 got=%0d/%0d required=%0d/0", k, cnt, TL);
    end
    @(posedge clk); #1;
    run_xfer(16'hFFFF, 5'd20, 1'b0, k, w, cnt, rdy);
    total++;
    if (k != W + TL) begin
      bad++;
      $display("FAIL len_sat_latency got=%0d required=%0d", k, W + TL);
    end
    total++;
    if (int'(cnt) != model_cnt(16'hFFFF, 20) || cnt !== 5'd14) begin
      bad++;
      $display("FAIL len_sat_count got=%0d required=14", cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_len_edges();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
